// File: rtl/lcd_value_writer_if.sv
// Host-side request channel of lcd_value_writer.
//   start   : level-sampled request, only honoured while the writer is idle
//   data_in : 16-bit two's-complement value, captured on the acceptance cycle
//   busy    : writer is initialising the panel or still emitting a value
// master = requester (CPU display path), slave = lcd_value_writer.
interface lcd_value_writer_if;
  logic        start;
  logic [15:0] data_in;
  logic        busy;

  modport master (output start, output data_in, input busy);
  modport slave  (input start, input data_in, output busy);
endinterface

// File: rtl/lcd_value_writer.sv
// lcd_value_writer: converts a signed 16-bit value to decimal ASCII with a
// sequential double-dabble and writes it to an HD44780 16x2 panel (8-bit,
// write-only) at row 0 col 0. Performs the power-up init sequence first.
//
// Ports:
//   clk       50 MHz system clock
//   ligar     asynchronous active-low reset
//   host      request channel (start / data_in / busy), slave side
//   LCD_DATA  panel data bus          LCD_RS   0 = command, 1 = data
//   LCD_EN    panel strobe            LCD_RW   tied 0
//   LCD_ON    tied 1                  LCD_BLON tied 1
//
// Optional feature macro LCD_SHOW_HEX_EN: when defined, each transaction also
// writes "0x" plus four uppercase hex digits of the raw value on row 1.
module lcd_value_writer #(
  parameter int unsigned EN_CYCLES       = 25,
  parameter int unsigned CMD_WAIT_CYCLES = 2500,
  parameter int unsigned CLR_WAIT_CYCLES = 100000,
  parameter int unsigned PWRUP_CYCLES    = 1000000
) (
  input  logic               clk,
  input  logic               ligar,
  lcd_value_writer_if.slave  host,
  output logic [7:0]         LCD_DATA,
  output logic               LCD_RS,
  output logic               LCD_RW,
  output logic               LCD_EN,
  output logic               LCD_ON,
  output logic               LCD_BLON
);

  typedef enum logic [2:0] {
    PWR_WAIT, INIT, IDLE, CONVERT, SEND_SETUP, SEND_EN, SEND_WAIT
  } state_t;

`ifdef LCD_SHOW_HEX_EN
  localparam logic [3:0] LAST_TXN_IDX = 4'd13;
`else
  localparam logic [3:0] LAST_TXN_IDX = 4'd6;
`endif
  localparam logic [3:0] LAST_INIT_IDX = 4'd3;

  state_t      state, state_nxt;
  logic [31:0] cnt;        // cycles spent in the current state
  logic [3:0]  idx;        // byte index within init or transaction list
  logic        in_init;    // SEND_* currently walks the init list
  logic        sign;
  logic [35:0] dd;         // double-dabble shifter {bcd[19:0], bin[15:0]}
  logic [15:0] mag;
  logic [7:0]  cur_byte;
  logic        cur_rs;
  logic [31:0] wait_len;
  logic        last_byte;
  logic [19:0] bcd;
`ifdef LCD_SHOW_HEX_EN
  logic [15:0] raw;
`endif

  assign bcd = dd[35:16];
  assign mag = host.data_in[15] ? (~host.data_in + 16'd1) : host.data_in;

  // One double-dabble iteration: add 3 to any BCD nibble >= 5, then shift.
  function automatic logic [35:0] dd_step(input logic [35:0] s);
    logic [35:0] t;
    t = s;
    for (int i = 0; i < 5; i++)
      if (t[16+4*i +: 4] >= 4'd5) t[16+4*i +: 4] = t[16+4*i +: 4] + 4'd3;
    return {t[34:0], 1'b0};
  endfunction

`ifdef LCD_SHOW_HEX_EN
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
  endfunction
`endif

  // Byte for the current index; digits go out most significant first.
  always_comb begin
    cur_byte = 8'h00;
    cur_rs   = 1'b0;
    if (in_init) begin
      case (idx)
        4'd0:    cur_byte = 8'h38;
        4'd1:    cur_byte = 8'h0C;
        4'd2:    cur_byte = 8'h01;
        default: cur_byte = 8'h06;
      endcase
    end else begin
      cur_rs = 1'b1;
      case (idx)
        4'd0:  begin cur_byte = 8'h80; cur_rs = 1'b0; end
        4'd1:  cur_byte = sign ? 8'h2D : 8'h20;
        4'd2:  cur_byte = 8'h30 + {4'd0, bcd[19:16]};
        4'd3:  cur_byte = 8'h30 + {4'd0, bcd[15:12]};
        4'd4:  cur_byte = 8'h30 + {4'd0, bcd[11:8]};
        4'd5:  cur_byte = 8'h30 + {4'd0, bcd[7:4]};
        4'd6:  cur_byte = 8'h30 + {4'd0, bcd[3:0]};
`ifdef LCD_SHOW_HEX_EN
        4'd7:  begin cur_byte = 8'hC0; cur_rs = 1'b0; end
        4'd8:  cur_byte = 8'h30;
        4'd9:  cur_byte = 8'h78;
        4'd10: cur_byte = hex_char(raw[15:12]);
        4'd11: cur_byte = hex_char(raw[11:8]);
        4'd12: cur_byte = hex_char(raw[7:4]);
        4'd13: cur_byte = hex_char(raw[3:0]);
`endif
        default: cur_byte = 8'h00;
      endcase
    end
  end

  // Only the clear-display command needs the long wait.
  assign wait_len  = (in_init && idx == 4'd2) ? CLR_WAIT_CYCLES : CMD_WAIT_CYCLES;
  assign last_byte = in_init ? (idx == LAST_INIT_IDX) : (idx == LAST_TXN_IDX);

  // State register
  always_ff @(posedge clk or negedge ligar) begin
    if (!ligar) state <= PWR_WAIT;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      PWR_WAIT:   if (cnt == PWRUP_CYCLES - 1) state_nxt = INIT;
      INIT:       state_nxt = SEND_SETUP;
      IDLE:       if (host.start) state_nxt = CONVERT;
      CONVERT:    if (cnt == 32'd15) state_nxt = SEND_SETUP;
      SEND_SETUP: state_nxt = SEND_EN;
      SEND_EN:    if (cnt == EN_CYCLES - 1) state_nxt = SEND_WAIT;
      SEND_WAIT:  if (cnt == wait_len - 1) state_nxt = last_byte ? IDLE : SEND_SETUP;
      default:    state_nxt = PWR_WAIT;
    endcase
  end

  // Outputs: EN and busy decode straight from state so reset drops them at once.
  always_comb begin
    host.busy = (state != IDLE);
    LCD_EN    = (state == SEND_EN);
    LCD_RW    = 1'b0;
    LCD_ON    = 1'b1;
    LCD_BLON  = 1'b1;
  end

  // Datapath: counter, byte index, conversion, panel bus registers.
  always_ff @(posedge clk or negedge ligar) begin
    if (!ligar) begin
      cnt      <= '0;
      idx      <= '0;
      in_init  <= 1'b1;
      sign     <= 1'b0;
      dd       <= '0;
      LCD_DATA <= 8'h00;
      LCD_RS   <= 1'b0;
`ifdef LCD_SHOW_HEX_EN
      raw      <= '0;
`endif
    end else begin
      if (state_nxt != state) cnt <= '0;
      else if (state != IDLE) cnt <= cnt + 32'd1;

      case (state)
        INIT: begin
          in_init <= 1'b1;
          idx     <= '0;
        end
        IDLE: if (host.start) begin
          in_init <= 1'b0;
          idx     <= '0;
          sign    <= host.data_in[15];
          dd      <= {20'd0, mag};
`ifdef LCD_SHOW_HEX_EN
          raw     <= host.data_in;
`endif
        end
        CONVERT:    dd <= dd_step(dd);
        SEND_SETUP: begin
          LCD_DATA <= cur_byte;
          LCD_RS   <= cur_rs;
        end
        SEND_WAIT: if (cnt == wait_len - 1 && !last_byte) idx <= idx + 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_value_writer.sv
// Self-checking bench for lcd_value_writer with shortened timing parameters.
// Bytes strobed on the panel are captured at every EN rise and compared with
// a reference list built from the value with plain integer arithmetic.
module tb_lcd_value_writer;
  localparam int EN   = 2;
  localparam int CMDW = 4;
  localparam int CLRW = 8;
  localparam int PWR  = 10;

  logic clk = 1'b0;
  logic ligar = 1'b0;
  always #5 clk = ~clk;

  lcd_value_writer_if hif();
  logic [7:0] lcd_data;
  logic lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;

  lcd_value_writer #(
    .EN_CYCLES(EN), .CMD_WAIT_CYCLES(CMDW),
    .CLR_WAIT_CYCLES(CLRW), .PWRUP_CYCLES(PWR)
  ) u_dut (
    .clk(clk), .ligar(ligar), .host(hif),
    .LCD_DATA(lcd_data), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw),
    .LCD_EN(lcd_en), .LCD_ON(lcd_on), .LCD_BLON(lcd_blon)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Panel monitor
  logic [8:0] cap[$];
  int rise_q[$];
  int fall_q[$];
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (lcd_en && !prev_en) begin
      cap.push_back({lcd_rs, lcd_data});
      rise_q.push_back(cyc);
    end
    if (!lcd_en && prev_en) fall_q.push_back(cyc);
    prev_en = lcd_en;
  end

  logic [8:0] exp[$];

  task automatic clear_mon();
    cap.delete(); rise_q.delete(); fall_q.delete(); exp.delete();
  endtask

  task automatic build_init();
    exp.push_back({1'b0, 8'h38});
    exp.push_back({1'b0, 8'h0C});
    exp.push_back({1'b0, 8'h01});
    exp.push_back({1'b0, 8'h06});
  endtask

  // Expected panel bytes for one value, straight from the display rules.
  task automatic build_txn(input logic [15:0] v);
    int mag, p, d, n;
    mag = v[15] ? (65536 - int'(v)) : int'(v);
    exp.push_back({1'b0, 8'h80});
    exp.push_back({1'b1, v[15] ? 8'h2D : 8'h20});
    p = 10000;
    for (int k = 0; k < 5; k++) begin
      d = (mag / p) % 10;
      exp.push_back({1'b1, 8'(48 + d)});
      p = p / 10;
    end
`ifdef LCD_SHOW_HEX_EN
    exp.push_back({1'b0, 8'hC0});
    exp.push_back({1'b1, 8'h30});
    exp.push_back({1'b1, 8'h78});
    for (int k = 0; k < 4; k++) begin
      n = (int'(v) >> (12 - 4 * k)) & 15;
      exp.push_back({1'b1, 8'(n < 10 ? 48 + n : 55 + n)});
    end
`else
    n = 0;
`endif
  endtask

  task automatic start_pulse(input logic [15:0] v);
    @(negedge clk);
    hif.data_in = v;
    hif.start = 1'b1;
    @(negedge clk);
    hif.start = 1'b0;
  endtask

  task automatic wait_idle(input int max, output bit ok, output int at);
    ok = 1'b0; at = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk); #1;
      if (!hif.busy) begin ok = 1'b1; at = cyc; break; end
    end
  endtask

  task automatic test_reset();
    ligar = 1'b0; hif.start = 1'b0; hif.data_in = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (hif.busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b want=1", hif.busy); end
    checks++; if (lcd_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%b want=0", lcd_en); end
    checks++; if (lcd_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h want=00", lcd_data); end
    checks++; if (lcd_rs !== 1'b0) begin failures++; $display("FAIL reset_rs got=%b want=0", lcd_rs); end
    checks++; if ({lcd_rw, lcd_on, lcd_blon} !== 3'b011) begin
      failures++; $display("FAIL tied_pins got=%b want=011", {lcd_rw, lcd_on, lcd_blon}); end
  endtask

  task automatic test_init();
    bit ok; int at, r, gap, wt;
    clear_mon();
    build_init();
    @(negedge clk);
    r = cyc;
    ligar = 1'b1;
    wait_idle(600, ok, at);
    checks++; if (!ok) begin failures++; $display("FAIL init_timeout got=busy want=idle"); end
    checks++; if (cap.size() != 4) begin failures++; $display("FAIL init_count got=%0d want=4", cap.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= cap.size() || cap[i] !== exp[i]) begin
        failures++; $display("FAIL init_byte%0d got=%h want=%h", i, (i < cap.size()) ? cap[i] : 9'h0, exp[i]);
      end
    end
    if (rise_q.size() == 4 && fall_q.size() == 4) begin
      checks++;
      if (rise_q[0] - r < PWR + 1 || rise_q[0] - r > PWR + 3) begin
        failures++; $display("FAIL pwrup_delay got=%0d want=%0d..%0d", rise_q[0] - r, PWR + 1, PWR + 3);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (fall_q[i] - rise_q[i] != EN) begin
          failures++; $display("FAIL init_en_width%0d got=%0d want=%0d", i, fall_q[i] - rise_q[i], EN);
        end
      end
      for (int i = 0; i < 3; i++) begin
        wt = (i == 2) ? CLRW : CMDW;
        gap = rise_q[i + 1] - fall_q[i];
        checks++;
        if (gap != wt + 1) begin
          failures++; $display("FAIL init_wait%0d got=%0d want=%0d", i, gap, wt + 1);
        end
      end
      checks++;
      if (at - fall_q[3] != CMDW) begin
        failures++; $display("FAIL init_busy_fall got=%0d want=%0d", at - fall_q[3], CMDW);
      end
    end
  endtask

  task automatic test_decimal();
    logic [15:0] vals[$];
    logic [15:0] v;
    bit ok; int at;
    vals = '{16'h007B, 16'hFFD6, 16'h0000, 16'h8000, 16'h7FFF};
    for (int k = 0; k < 6; k++) vals.push_back(16'($urandom));
    foreach (vals[j]) begin
      v = vals[j];
      clear_mon();
      build_txn(v);
      start_pulse(v);
      #1;
      checks++; if (hif.busy !== 1'b1) begin failures++; $display("FAIL accept_busy val=%h got=%b want=1", v, hif.busy); end
      wait_idle(600, ok, at);
      checks++; if (!ok) begin failures++; $display("FAIL txn_timeout val=%h got=busy want=idle", v); end
      checks++;
      if (cap.size() != exp.size()) begin
        failures++; $display("FAIL txn_count val=%h got=%0d want=%0d", v, cap.size(), exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (i >= cap.size() || cap[i] !== exp[i]) begin
          failures++; $display("FAIL txn_byte%0d val=%h got=%h want=%h", i, v, (i < cap.size()) ? cap[i] : 9'h0, exp[i]);
        end
      end
      if (ok && fall_q.size() > 0) begin
        checks++;
        if (at - fall_q[$] != CMDW) begin
          failures++; $display("FAIL txn_busy_fall val=%h got=%0d want=%0d", v, at - fall_q[$], CMDW);
        end
      end
    end
  endtask

  task automatic test_ignore_busy();
    bit ok; int at, n;
    clear_mon();
    build_txn(16'h0001);
    start_pulse(16'h0001);
    repeat (20) @(negedge clk);
    start_pulse(16'h0999);
    wait_idle(600, ok, at);
    checks++; if (!ok) begin failures++; $display("FAIL ignore_timeout got=busy want=idle"); end
    n = cap.size();
    checks++; if (n != exp.size()) begin failures++; $display("FAIL ignore_count got=%0d want=%0d", n, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= cap.size() || cap[i] !== exp[i]) begin
        failures++; $display("FAIL ignore_byte%0d got=%h want=%h", i, (i < cap.size()) ? cap[i] : 9'h0, exp[i]);
      end
    end
    repeat (60) @(negedge clk);
    #1;
    checks++; if (hif.busy !== 1'b0) begin failures++; $display("FAIL ignore_busy_after got=%b want=0", hif.busy); end
    checks++; if (cap.size() != n) begin failures++; $display("FAIL ignore_extra got=%0d want=%0d", cap.size(), n); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b;
    bit ok, seen; int at;
    a = 16'($urandom); b = 16'($urandom);
    clear_mon();
    build_txn(a);
    build_txn(b);
    @(negedge clk);
    hif.data_in = a; hif.start = 1'b1;
    @(negedge clk); #1;
    checks++; if (hif.busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b want=1", hif.busy); end
    hif.data_in = b;
    seen = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (cap.size() > exp.size() / 2) begin seen = 1'b1; break; end
    end
    hif.start = 1'b0;
    checks++; if (!seen) begin failures++; $display("FAIL b2b_second_start got=none want=started"); end
    wait_idle(800, ok, at);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout got=busy want=idle"); end
    checks++; if (cap.size() != exp.size()) begin failures++; $display("FAIL b2b_count got=%0d want=%0d", cap.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= cap.size() || cap[i] !== exp[i]) begin
        failures++; $display("FAIL b2b_byte%0d got=%h want=%h", i, (i < cap.size()) ? cap[i] : 9'h0, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok, seen; int at;
    clear_mon();
    start_pulse(16'h1234);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (lcd_en) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin failures++; $display("FAIL mid_en_seen got=none want=strobe"); end
    ligar = 1'b0;
    #1;
    checks++; if (lcd_en !== 1'b0) begin failures++; $display("FAIL mid_en_drop got=%b want=0", lcd_en); end
    checks++; if (hif.busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b want=1", hif.busy); end
    checks++; if (lcd_data !== 8'h00) begin failures++; $display("FAIL mid_data got=%h want=00", lcd_data); end
    @(negedge clk); #1;
    clear_mon();
    build_init();
    build_txn(16'h4321);
    @(negedge clk);
    ligar = 1'b1; hif.start = 1'b1; hif.data_in = 16'h4321;
    seen = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (cap.size() >= 5) begin seen = 1'b1; break; end
    end
    hif.start = 1'b0;
    checks++; if (!seen) begin failures++; $display("FAIL mid_restart got=%0d want>=5", cap.size()); end
    wait_idle(600, ok, at);
    checks++; if (!ok) begin failures++; $display("FAIL mid_timeout got=busy want=idle"); end
    checks++; if (cap.size() != exp.size()) begin failures++; $display("FAIL mid_count got=%0d want=%0d", cap.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= cap.size() || cap[i] !== exp[i]) begin
        failures++; $display("FAIL mid_byte%0d got=%h want=%h", i, (i < cap.size()) ? cap[i] : 9'h0, exp[i]);
      end
    end
  endtask

  initial begin
    hif.start = 1'b0;
    hif.data_in = '0;
    test_reset();
    test_init();
    test_decimal();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
